dcache_wt: RTL and testbench
============================

DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 SHALL have parameters: NUM_COL, default 4, byte columns per word; COL_WIDTH, default 8, bits per column; ADDR_WIDTH, default 30, word-address width; INDEX_WIDTH, default 8, set-index bits; OFFSET_WIDTH, default 2, word-in-line bits (LINE_WORDS=2**OFFSET_WIDTH); DATA_WIDTH, default NUM_COL*COL_WIDTH, derived.
REQ-002 SHALL have ports, one clock and synchronous active-high reset (already decided):
  clock  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  cpu_req_valid/cpu_req_ready  in/out  1  CPU request handshake
  cpu_req_wen  in  1  1=write, 0=read
  cpu_req_we  in  NUM_COL  byte enables (writes)
  cpu_req_addr  in  ADDR_WIDTH  word address
  cpu_req_wdata  in  DATA_WIDTH  write data
  cpu_resp_valid  out  1  one-cycle response pulse
  cpu_resp_rdata  out  DATA_WIDTH  read data, valid with pulse
  mem_rd_valid/mem_rd_ready  out/in  1  line-fill request handshake
  mem_rd_addr  out  ADDR_WIDTH  line-aligned address, offset bits zero
  mem_rd_data_valid  in  1  fill beat strobe, no backpressure
  mem_rd_data  in  DATA_WIDTH  fill beat, ascending word order
  mem_wr_valid/mem_wr_ready  out/in  1  write-through handshake
  mem_wr_addr/mem_wr_we/mem_wr_data  out  ADDR_WIDTH/NUM_COL/DATA_WIDTH  write-through payload

Function
REQ-003 SHALL be direct-mapped, write-through, no-write-allocate; address = {tag, index[INDEX_WIDTH], offset[OFFSET_WIDTH]}.
REQ-004 SHALL implement FSM states INIT, IDLE, LOOKUP, FILL_REQ, FILL, WRITE, RESP.
REQ-005 INIT SHALL clear one valid/tag entry per cycle, 2**INDEX_WIDTH cycles, then enter IDLE; cpu_req_ready=0 throughout.
REQ-006 cpu_req_ready SHALL be 1 only in IDLE; accept (valid&ready) registers the request, issues synchronous tag/data read, enters LOOKUP.
REQ-007 Read hit in LOOKUP SHALL go to RESP; cpu_resp_valid high exactly one cycle, two cycles after the accept cycle, then IDLE.
REQ-008 Read miss SHALL go to FILL_REQ: mem_rd_valid held with stable mem_rd_addr until mem_rd_ready, then FILL.
REQ-009 FILL SHALL write each beat into the data array at a wrapping beat counter; the beat matching the request offset SHALL be captured; after beat LINE_WORDS-1, tag written and valid set, RESP with captured word.
REQ-010 Write (hit or miss) SHALL go to WRITE; on hit, only enabled bytes of the cached word SHALL be updated, in the LOOKUP cycle; a miss SHALL leave arrays unchanged.
REQ-011 WRITE SHALL hold mem_wr_valid with stable payload until mem_wr_ready, then RESP (write ack, cpu_resp_rdata don't-care).
REQ-012 A write with cpu_req_we all-zero SHALL still be forwarded and acked.
REQ-013 mem_rd_data_valid outside FILL SHALL be ignored.
REQ-014 Read of a line just filled SHALL hit.

Reset
REQ-015 Reset SHALL force INIT from any state, including mid-fill or mid-write; in-flight memory transactions abandoned.
REQ-016 The cycle after reset, cpu_req_ready, cpu_resp_valid, mem_rd_valid and mem_wr_valid SHALL be 0; beat counter SHALL be 0.

Configuration
REQ-017 With DCACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count (32 bits, wrapping, cleared by reset), each incremented once per lookup hit/miss, reads and writes.
REQ-018 Without DCACHE_STATS_EN, those ports and counters SHALL be absent; behaviour otherwise identical.

Structure
REQ-019 The state enum, derived widths (TAG_WIDTH=ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH, LINE_WORDS) and field-extraction constants SHALL live in shared package dcache_pkg.
REQ-020 Data array SHALL be sub-module dcache_data_ram: simple dual-port, per-column write enables, registered synchronous read; tag/valid array inferred in dcache_wt.

Verification
REQ-021 Reset then idle -> cpu_req_ready 0 for 256 cycles (INIT, defaults), 1 after.
REQ-022 Read 0x100 cold -> mem_rd_addr=0x100, 4 beats 0xA0..0xA3 -> cpu_resp_rdata=0xA0; repeat read 0x102 -> 0xA2, no mem_rd_valid, resp 2 cycles after accept.
REQ-023 After REQ-022, write 0x101 we=4'b0010 wdata=0x0000_5500 -> mem_wr_we=4'b0010, ack; read 0x101 -> 0x0000_55A1.
REQ-024 Write miss 0x900 -> mem write issued, mem_wr_ready delayed 5 cycles, ack after; read 0x900 still misses.
REQ-025 Reset asserted at fill beat 2 -> all valid outputs 0 next cycle, INIT re-entered, later read of 0x100 misses.
REQ-026 With DCACHE_STATS_EN, sequence of REQ-022/023 -> hit_count=2, miss_count=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the write-through data cache.
// Optional hit/miss counters are enabled with DCACHE_STATS_EN.
package dcache_pkg;

  localparam int DEF_NUM_COL      = 4;
  localparam int DEF_COL_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH   = 30;
  localparam int DEF_INDEX_WIDTH  = 8;
  localparam int DEF_OFFSET_WIDTH = 2;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    FILL_REQ,
    FILL,
    WRITE,
    RESP
  } state_t;

  function automatic int tag_width(
    input int aw,
    input int iw,
    input int ow
  );
    return aw - iw - ow;
  endfunction

  function automatic int line_words(input int ow);
    return 1 << ow;
  endfunction

  function automatic int idx_lsb(input int ow);
    return ow;
  endfunction

  function automatic int tag_lsb(
    input int iw,
    input int ow
  );
    return iw + ow;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side buses of the data cache.
// master = side that issues requests on that bus.
interface dcache_cpu_if #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
);
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_req_wen;
  logic [NUM_COL-1:0]    cpu_req_we;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic [DATA_WIDTH-1:0] cpu_req_wdata;
  logic                  cpu_resp_valid;
  logic [DATA_WIDTH-1:0] cpu_resp_rdata;

  modport master (
    output cpu_req_valid, cpu_req_wen,
    output cpu_req_we, cpu_req_addr,
    output cpu_req_wdata,
    input  cpu_req_ready, cpu_resp_valid,
    input  cpu_resp_rdata
  );

  modport slave (
    input  cpu_req_valid, cpu_req_wen,
    input  cpu_req_we, cpu_req_addr,
    input  cpu_req_wdata,
    output cpu_req_ready, cpu_resp_valid,
    output cpu_resp_rdata
  );
endinterface

interface dcache_mem_if #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
);
  logic                  mem_rd_valid;
  logic                  mem_rd_ready;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_data_valid;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_wr_valid;
  logic                  mem_wr_ready;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [NUM_COL-1:0]    mem_wr_we;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport master (
    output mem_rd_valid, mem_rd_addr,
    output mem_wr_valid, mem_wr_addr,
    output mem_wr_we, mem_wr_data,
    input  mem_rd_ready, mem_rd_data_valid,
    input  mem_rd_data, mem_wr_ready
  );

  modport slave (
    input  mem_rd_valid, mem_rd_addr,
    input  mem_wr_valid, mem_wr_addr,
    input  mem_wr_we, mem_wr_data,
    output mem_rd_ready, mem_rd_data_valid,
    output mem_rd_data, mem_wr_ready
  );
endinterface

// File: rtl/dcache_data_ram.sv
// Simple dual-port data array: per-column write enables,
// registered synchronous read (old data on same-address collision).
module dcache_data_ram #(
  parameter int NUM_COL   = 4,
  parameter int COL_WIDTH = 8,
  parameter int AW        = 10
) (
  input  logic                         clk,
  input  logic [NUM_COL-1:0]           wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [NUM_COL*COL_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic [AW-1:0]                rd_addr,
  output logic [NUM_COL*COL_WIDTH-1:0] rd_data
);

  logic [NUM_COL-1:0][COL_WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (wr_en[c]) begin
        mem[wr_addr][c] <=
          wr_data[c*COL_WIDTH +: COL_WIDTH];
      end
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to add hit_count/miss_count outputs.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int NUM_COL      = DEF_NUM_COL,
  parameter int COL_WIDTH    = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int DATA_WIDTH   = NUM_COL * COL_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int TAG_WIDTH =
    tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
  localparam int LINE_WORDS = line_words(OFFSET_WIDTH);
  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int RAM_AW     = INDEX_WIDTH + OFFSET_WIDTH;
  localparam int IDX_LSB    = idx_lsb(OFFSET_WIDTH);
  localparam int TAG_LSB    =
    tag_lsb(INDEX_WIDTH, OFFSET_WIDTH);

  state_t state_q, state_d;

  logic                    req_wen_q, req_wen_d;
  logic [NUM_COL-1:0]      req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [INDEX_WIDTH-1:0]  init_idx_q, init_idx_d;
  logic [OFFSET_WIDTH-1:0] beat_q, beat_d;

  logic [TAG_WIDTH-1:0] tag_mem [SETS];
  logic [SETS-1:0]      valid_mem;
  logic [TAG_WIDTH-1:0] tag_rd_q;
  logic                 valid_rd_q;

  logic [INDEX_WIDTH-1:0]  req_idx, in_idx;
  logic [OFFSET_WIDTH-1:0] req_off;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic                    accept, hit;

  logic                   tag_we, tag_wr_valid;
  logic [INDEX_WIDTH-1:0] tag_wr_idx;
  logic [TAG_WIDTH-1:0]   tag_wr_tag;
  logic [NUM_COL-1:0]     ram_we;
  logic [RAM_AW-1:0]      ram_waddr;
  logic [DATA_WIDTH-1:0]  ram_wdata, ram_rdata;
  logic ready, resp_valid, rd_valid, wr_valid;

  assign req_idx = req_addr_q[IDX_LSB +: INDEX_WIDTH];
  assign req_off = req_addr_q[OFFSET_WIDTH-1:0];
  assign req_tag = req_addr_q[TAG_LSB +: TAG_WIDTH];
  assign in_idx  = cpu.cpu_req_addr[IDX_LSB +: INDEX_WIDTH];
  assign accept  = cpu.cpu_req_valid && (state_q == IDLE);
  assign hit     = valid_rd_q && (tag_rd_q == req_tag);

  always_comb begin
    state_d      = state_q;
    req_wen_d    = req_wen_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    rdata_d      = rdata_q;
    init_idx_d   = init_idx_q;
    beat_d       = beat_q;
    ready        = 1'b0;
    resp_valid   = 1'b0;
    rd_valid     = 1'b0;
    wr_valid     = 1'b0;
    tag_we       = 1'b0;
    tag_wr_valid = 1'b0;
    tag_wr_idx   = req_idx;
    tag_wr_tag   = req_tag;
    ram_we       = '0;
    ram_waddr    = {req_idx, req_off};
    ram_wdata    = req_wdata_q;
    unique case (state_q)
      INIT: begin
        tag_we     = 1'b1;
        tag_wr_idx = init_idx_q;
        tag_wr_tag = '0;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == INDEX_WIDTH'(SETS - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        ready = 1'b1;
        if (cpu.cpu_req_valid) begin
          req_wen_d   = cpu.cpu_req_wen;
          req_we_d    = cpu.cpu_req_we;
          req_addr_d  = cpu.cpu_req_addr;
          req_wdata_d = cpu.cpu_req_wdata;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_wen_q) begin
          if (hit) ram_we = req_we_q;
          state_d = WRITE;
        end else if (hit) begin
          rdata_d = ram_rdata;
          state_d = RESP;
        end else begin
          beat_d  = '0;
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        rd_valid = 1'b1;
        if (mem.mem_rd_ready) state_d = FILL;
      end
      FILL: begin
        if (mem.mem_rd_data_valid) begin
          ram_we    = '1;
          ram_waddr = {req_idx, beat_q};
          ram_wdata = mem.mem_rd_data;
          beat_d    = beat_q + 1'b1;
          if (beat_q == req_off) begin
            rdata_d = mem.mem_rd_data;
          end
          if (beat_q == OFFSET_WIDTH'(LINE_WORDS - 1)) begin
            tag_we       = 1'b1;
            tag_wr_valid = 1'b1;
            state_d      = RESP;
          end
        end
      end
      WRITE: begin
        wr_valid = 1'b1;
        if (mem.mem_wr_ready) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = INIT;
    endcase
    // Abandoned fills/writes must not touch the arrays.
    if (reset) begin
      ram_we = '0;
      tag_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      beat_q     <= beat_d;
    end
  end

  always_ff @(posedge clock) begin
    req_wen_q   <= req_wen_d;
    req_we_q    <= req_we_d;
    req_addr_q  <= req_addr_d;
    req_wdata_q <= req_wdata_d;
    rdata_q     <= rdata_d;
  end

  always_ff @(posedge clock) begin
    if (tag_we) begin
      tag_mem[tag_wr_idx]   <= tag_wr_tag;
      valid_mem[tag_wr_idx] <= tag_wr_valid;
    end
    if (accept) begin
      tag_rd_q   <= tag_mem[in_idx];
      valid_rd_q <= valid_mem[in_idx];
    end
  end

  dcache_data_ram #(
    .NUM_COL   (NUM_COL),
    .COL_WIDTH (COL_WIDTH),
    .AW        (RAM_AW)
  ) u_data_ram (
    .clk     (clock),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (accept),
    .rd_addr (cpu.cpu_req_addr[RAM_AW-1:0]),
    .rd_data (ram_rdata)
  );

  assign cpu.cpu_req_ready  = ready;
  assign cpu.cpu_resp_valid = resp_valid;
  assign cpu.cpu_resp_rdata = rdata_q;

  assign mem.mem_rd_valid = rd_valid;
  assign mem.mem_rd_addr  =
    {req_addr_q[ADDR_WIDTH-1:OFFSET_WIDTH],
     OFFSET_WIDTH'(0)};
  assign mem.mem_wr_valid = wr_valid;
  assign mem.mem_wr_addr  = req_addr_q;
  assign mem.mem_wr_we    = req_we_q;
  assign mem.mem_wr_data  = req_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == LOOKUP) begin
      if (hit) hit_count_d = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt with a line-level reference model.
// Build with DCACHE_STATS_EN to also check the hit/miss counters.
module tb_dcache_wt;

  logic clock;
  logic reset;

  dcache_cpu_if cpu_bus ();
  dcache_mem_if mem_bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_wt dut (
    .clock (clock),
    .reset (reset),
    .cpu   (cpu_bus),
    .mem   (mem_bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          rd;
    bit          hit;
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  // Model: backing memory is the truth for data; the cache
  // only decides hit or miss via per-set valid/tag.
  bit          mvalid [256];
  logic [19:0] mtag   [256];
  logic [31:0] bmem   [int];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  bit chk_en   = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] req
  );
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  function automatic logic [31:0] bword(
    input logic [29:0] a
  );
    if (bmem.exists(int'(a))) return bmem[int'(a)];
    if (a[29:2] == 28'h40) return 32'hA0 + 32'(a[1:0]);
    return {a[15:0], 16'hBEEF};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    cyc++;
    if (chk_en) begin
      if (cpu_bus.cpu_req_valid && cpu_bus.cpu_req_ready)
        acc_cyc = cyc;
      if (cpu_bus.cpu_resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          if (cur.rd) begin
            chk("resp_rdata",
                cpu_bus.cpu_resp_rdata, cur.data);
            if (cur.hit)
              chk("hit_latency", cyc - acc_cyc, 2);
          end
        end
      end
      if (mem_bus.mem_rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          cur = exp_q[0];
          chk("rd_is_miss", cur.rd && !cur.hit, 1);
          chk("rd_addr", mem_bus.mem_rd_addr,
              {cur.addr[29:2], 2'b00});
        end
      end
      if (mem_bus.mem_wr_valid) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          cur = exp_q[0];
          chk("wr_is_write", cur.rd, 0);
          chk("wr_addr", mem_bus.mem_wr_addr, cur.addr);
          chk("wr_we", mem_bus.mem_wr_we, cur.we);
          chk("wr_data", mem_bus.mem_wr_data, cur.data);
        end
      end
    end
  end

  task automatic issue(
    input bit          wen,
    input logic [29:0] a,
    input logic [3:0]  we,
    input logic [31:0] wd
  );
    bit acc = 0;
    cpu_bus.cpu_req_valid = 1'b1;
    cpu_bus.cpu_req_wen   = wen;
    cpu_bus.cpu_req_addr  = a;
    cpu_bus.cpu_req_we    = we;
    cpu_bus.cpu_req_wdata = wd;
    for (int k = 0; k < 20; k++) begin
      if (cpu_bus.cpu_req_ready) begin
        tick();
        acc = 1;
        break;
      end
      tick();
    end
    cpu_bus.cpu_req_valid = 1'b0;
    chk("req_accept", acc, 1);
  endtask

  task automatic wait_resp(
    input bit          use_lit,
    input logic [31:0] lit
  );
    bit got = 0;
    for (int k = 0; k < 10; k++) begin
      if (cpu_bus.cpu_resp_valid) begin
        got = 1;
        break;
      end
      tick();
    end
    chk("resp_seen", got, 1);
    if (got && use_lit)
      chk("resp_literal", cpu_bus.cpu_resp_rdata, lit);
  endtask

  task automatic do_read(
    input logic [29:0] a,
    input bit          exp_hit,
    input int          rd_dly,
    input int          rst_beat,
    input logic [31:0] lit
  );
    exp_t e;
    bit   mh, seen, seen_miss;
    int   idx;
    idx = int'(a[9:2]);
    mh  = mvalid[idx] && (mtag[idx] == a[29:10]);
    e.rd = 1; e.hit = mh; e.addr = a;
    e.we = '0; e.data = bword(a);
    exp_q.push_back(e);
    if (!mh) begin
      mvalid[idx] = 1;
      mtag[idx]   = a[29:10];
    end
    issue(0, a, 4'h0, 32'h0);
    seen = 0;
    seen_miss = 0;
    for (int k = 0; k < 6; k++) begin
      if (mem_bus.mem_rd_valid || cpu_bus.cpu_resp_valid) begin
        seen = 1;
        seen_miss = mem_bus.mem_rd_valid;
        break;
      end
      tick();
    end
    chk("read_progress", seen, 1);
    chk("read_hit", !seen_miss, exp_hit);
    if (seen_miss) begin
      chk("fill_addr_lit", mem_bus.mem_rd_addr,
          {a[29:2], 2'b00});
      repeat (rd_dly) tick();
      mem_bus.mem_rd_ready = 1'b1;
      tick();
      mem_bus.mem_rd_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
        mem_bus.mem_rd_data_valid = 1'b1;
        mem_bus.mem_rd_data = bword({a[29:2], 2'(b)});
        if (b == rst_beat) begin
          chk_en = 0;
          exp_q.delete();
          reset = 1'b1;
          tick();
          reset = 1'b0;
          mem_bus.mem_rd_data_valid = 1'b0;
          chk("rst_req_ready", cpu_bus.cpu_req_ready, 0);
          chk("rst_resp_valid", cpu_bus.cpu_resp_valid, 0);
          chk("rst_rd_valid", mem_bus.mem_rd_valid, 0);
          chk("rst_wr_valid", mem_bus.mem_wr_valid, 0);
          chk("rst_beat", dut.beat_q, 0);
          for (int s = 0; s < 256; s++) mvalid[s] = 0;
          seen = 0;
          for (int k = 0; k < 300; k++) begin
            if (cpu_bus.cpu_req_ready) begin
              seen = 1;
              break;
            end
            tick();
          end
          chk("rst_reinit", seen, 1);
          chk_en = 1;
          return;
        end
        tick();
      end
      mem_bus.mem_rd_data_valid = 1'b0;
    end
    wait_resp(1, lit);
  endtask

  task automatic do_write(
    input logic [29:0] a,
    input logic [3:0]  we,
    input logic [31:0] wd,
    input int          dly
  );
    exp_t        e;
    logic [31:0] w;
    bit          seen = 0;
    w = bword(a);
    for (int i = 0; i < 4; i++)
      if (we[i]) w[i*8 +: 8] = wd[i*8 +: 8];
    bmem[int'(a)] = w;
    e.rd = 0; e.hit = 0; e.addr = a;
    e.we = we; e.data = wd;
    exp_q.push_back(e);
    issue(1, a, we, wd);
    for (int k = 0; k < 6; k++) begin
      if (mem_bus.mem_wr_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("wr_issued", seen, 1);
    chk("wr_we_lit", mem_bus.mem_wr_we, we);
    repeat (dly) tick();
    chk("wr_held", mem_bus.mem_wr_valid, 1);
    chk("wr_no_early_ack", cpu_bus.cpu_resp_valid, 0);
    mem_bus.mem_wr_ready = 1'b1;
    tick();
    mem_bus.mem_wr_ready = 1'b0;
    wait_resp(0, 32'h0);
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    cpu_bus.cpu_req_valid     = 1'b0;
    cpu_bus.cpu_req_wen       = 1'b0;
    cpu_bus.cpu_req_we        = '0;
    cpu_bus.cpu_req_addr      = '0;
    cpu_bus.cpu_req_wdata     = '0;
    mem_bus.mem_rd_ready      = 1'b0;
    mem_bus.mem_rd_data_valid = 1'b0;
    mem_bus.mem_rd_data       = '0;
    mem_bus.mem_wr_ready      = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("post_rst_ready", cpu_bus.cpu_req_ready, 0);
    chk("post_rst_resp", cpu_bus.cpu_resp_valid, 0);
    chk("post_rst_rd", mem_bus.mem_rd_valid, 0);
    chk("post_rst_wr", mem_bus.mem_wr_valid, 0);
    chk("post_rst_beat", dut.beat_q, 0);
    ok = 1;
    for (int k = 1; k < 256; k++) begin
      tick();
      if (cpu_bus.cpu_req_ready) ok = 0;
    end
    chk("init_ready_low_256", ok, 1);
    tick();
    chk("init_ready_high", cpu_bus.cpu_req_ready, 1);
    chk_en = 1;

    do_read(30'h100, 0, 0, -1, 32'h0000_00A0);
    do_read(30'h102, 1, 0, -1, 32'h0000_00A2);
    do_write(30'h101, 4'b0010, 32'h0000_5500, 0);
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 2);
    chk("miss_count", miss_count, 1);
`endif
    do_read(30'h101, 1, 0, -1, 32'h0000_55A1);

    do_write(30'h103, 4'b0000, 32'hFFFF_FFFF, 1);
    do_read(30'h103, 1, 0, -1, 32'h0000_00A3);

    tick();
    for (int k = 0; k < 3; k++) begin
      mem_bus.mem_rd_data_valid = 1'b1;
      mem_bus.mem_rd_data = 32'hFFFF_FFFF;
      tick();
    end
    mem_bus.mem_rd_data_valid = 1'b0;
    do_read(30'h102, 1, 0, -1, 32'h0000_00A2);

    do_read(30'h207, 0, 3, -1, 32'h0207_BEEF);
    do_read(30'h204, 1, 0, -1, 32'h0204_BEEF);

    do_write(30'h900, 4'b1111, 32'hDEAD_BEEF, 5);
    do_read(30'h900, 0, 0, -1, 32'hDEAD_BEEF);
    do_read(30'h100, 0, 0, -1, 32'h0000_00A0);

    do_read(30'h500, 0, 0, 2, 32'h0);
    do_read(30'h100, 0, 0, -1, 32'h0000_00A0);
    do_read(30'h101, 1, 0, -1, 32'h0000_55A1);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
